// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the issue stage, alu_seq_core and writeback.
// master drives requests and accepts results; slave is the core side.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             flag;
    logic             z;
    logic             n;
    logic             err;

    modport master (
        output in_valid, op_code, a, b, out_ready,
        input  in_ready, out_valid, res, flag, z, n, err
    );

    modport slave (
        input  in_valid, op_code, a, b, out_ready,
        output in_ready, out_valid, res, flag, z, n, err
    );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle add/sub/compare, bit-serial shifts and, when
// ALU_SEQ_MUL_EN is defined, an iterative shift-add multiplier.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// BUSY  | one shift step or one partial product per clock
// DONE  | result registered, out_valid high until out_ready
module alu_seq_core #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int CW = SHW + 1;

    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_SUB = 6'b010001;
    localparam logic [5:0] OP_EQ  = 6'b100000;
    localparam logic [5:0] OP_NEQ = 6'b100001;
    localparam logic [5:0] OP_LE  = 6'b100010;
    localparam logic [5:0] OP_GT  = 6'b100011;
    localparam logic [5:0] OP_SLL = 6'b110000;
    localparam logic [5:0] OP_SRL = 6'b110001;
    localparam logic [5:0] OP_SRA = 6'b110010;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [5:0]    OP_MUL  = 6'b010010;
    localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             flag_q, flag_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             err_q, err_d;

    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] sh_nxt;
    logic             sh_out;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;

    // Add the multiplicand into the upper half when the current multiplier bit is set, then shift right.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    assign mul_nxt = {mul_sum, prod_q[WIDTH-1:1]};
`endif

    assign amt   = bus.b[SHW-1:0];
    assign add_w = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_w = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        sh_nxt = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        sh_out = a_q[0];
        case (op_q)
            OP_SLL: begin
                sh_nxt = {a_q[WIDTH-2:0], 1'b0};
                sh_out = a_q[WIDTH-1];
            end
            OP_SRL: sh_nxt = {1'b0, a_q[WIDTH-1:1]};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flag_d  = flag_q;
        z_d     = z_q;
        n_d     = n_q;
        err_d   = err_q;
`ifdef ALU_SEQ_MUL_EN
        prod_d  = prod_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.op_code;
                    a_d     = bus.a;
                    res_d   = '0;
                    flag_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                    case (bus.op_code)
                        OP_ADD: begin
                            res_d  = add_w[WIDTH-1:0];
                            flag_d = add_w[WIDTH];
                        end
                        OP_SUB: begin
                            res_d  = sub_w[WIDTH-1:0];
                            flag_d = sub_w[WIDTH];
                        end
                        OP_EQ: begin
                            flag_d = (bus.a == bus.b);
                            res_d  = {{(WIDTH-1){1'b0}}, flag_d};
                        end
                        OP_NEQ: begin
                            flag_d = (bus.a != bus.b);
                            res_d  = {{(WIDTH-1){1'b0}}, flag_d};
                        end
                        OP_LE: begin
                            flag_d = ($signed(bus.a) <= $signed(bus.b));
                            res_d  = {{(WIDTH-1){1'b0}}, flag_d};
                        end
                        OP_GT: begin
                            flag_d = ($signed(bus.a) > $signed(bus.b));
                            res_d  = {{(WIDTH-1){1'b0}}, flag_d};
                        end
                        OP_SLL, OP_SRL, OP_SRA: begin
                            if (amt != '0) begin
                                cnt_d   = {1'b0, amt};
                                state_d = S_BUSY;
                            end else begin
                                res_d = bus.a;
                            end
                        end
`ifdef ALU_SEQ_MUL_EN
                        OP_MUL: begin
                            prod_d  = {{WIDTH{1'b0}}, bus.b};
                            cnt_d   = CNT_MUL;
                            state_d = S_BUSY;
                        end
`endif
                        default: err_d = 1'b1;
                    endcase
                    z_d = (res_d == '0);
                    n_d = res_d[WIDTH-1];
                end
            end
            S_BUSY: begin
                cnt_d  = cnt_q - 1'b1;
`ifdef ALU_SEQ_MUL_EN
                if (op_q == OP_MUL) begin
                    prod_d = mul_nxt;
                    res_d  = mul_nxt[WIDTH-1:0];
                    flag_d = |mul_nxt[2*WIDTH-1:WIDTH];
                end else begin
                    a_d    = sh_nxt;
                    res_d  = sh_nxt;
                    flag_d = sh_out;
                end
`else
                a_d    = sh_nxt;
                res_d  = sh_nxt;
                flag_d = sh_out;
`endif
                z_d = (res_d == '0);
                n_d = res_d[WIDTH-1];
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
            z_q     <= z_d;
            n_q     <= n_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= prod_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.res       = res_q;
    assign bus.flag      = flag_q;
    assign bus.z         = z_q;
    assign bus.n         = n_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed plus random checks of alu_seq_core (WIDTH=32) against an arithmetic reference model.
module tb_alu_seq_core;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    alu_seq_if #(.WIDTH(W)) bus_if ();

    alu_seq_core #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the opcode rules.
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic f, output logic e, output int lat);
        longint unsigned s;
        longint unsigned p;
        int k;
        k   = int'(b[4:0]);
        r   = '0;
        f   = 1'b0;
        e   = 1'b0;
        lat = 1;
        case (op)
            6'h10: begin s = longint'(a) + longint'(b); r = s[31:0]; f = (s > 64'hFFFF_FFFF); end
            6'h11: begin r = a - b; f = (a < b); end
            6'h20: f = (a == b);
            6'h21: f = (a != b);
            6'h22: f = ($signed(a) <= $signed(b));
            6'h23: f = ($signed(a) > $signed(b));
            6'h30: begin r = a << k; f = (k != 0) ? a[32-k] : 1'b0; lat = 1 + k; end
            6'h31: begin r = a >> k; f = (k != 0) ? a[k-1] : 1'b0; lat = 1 + k; end
            6'h32: begin r = $signed(a) >>> k; f = (k != 0) ? a[k-1] : 1'b0; lat = 1 + k; end
`ifdef ALU_SEQ_MUL_EN
            6'h12: begin p = longint'(a) * longint'(b); r = p[31:0]; f = (p[63:32] != 0); lat = 33; end
`endif
            default: e = 1'b1;
        endcase
        if (op inside {6'h20, 6'h21, 6'h22, 6'h23}) r = {31'b0, f};
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic ef, ee;
        int el, lat;
        model(op, a, b, er, ef, ee, el);
        @(negedge clk);
        chk({tag, ".in_ready"}, bus_if.in_ready, 1);
        bus_if.in_valid = 1'b1;
        bus_if.op_code  = op;
        bus_if.a        = a;
        bus_if.b        = b;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.a        = $urandom;
        bus_if.b        = $urandom;
        lat = 1;
        while (bus_if.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, el);
        chk({tag, ".res"}, bus_if.res, er);
        chk({tag, ".flag"}, bus_if.flag, ef);
        chk({tag, ".z"}, bus_if.z, (er == 0));
        chk({tag, ".n"}, bus_if.n, er[31]);
        chk({tag, ".err"}, bus_if.err, ee);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus_if.in_valid = 1'b1;
            bus_if.op_code  = 6'h10;
            bus_if.a        = $urandom;
            bus_if.b        = $urandom;
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, bus_if.out_valid, 1);
            chk({tag, ".hold_ready"}, bus_if.in_ready, 0);
            chk({tag, ".hold_res"}, bus_if.res, er);
            chk({tag, ".hold_flag"}, bus_if.flag, ef);
            chk({tag, ".hold_zn"}, {bus_if.z, bus_if.n}, {(er == 0), er[31]});
        end
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".idle_ready"}, bus_if.in_ready, 1);
        chk({tag, ".idle_valid"}, bus_if.out_valid, 0);
        @(negedge clk);
        bus_if.out_ready = 1'b0;
    endtask

    logic [5:0] ops [12];

    initial begin
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.op_code   = '0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        ops = '{6'h10, 6'h11, 6'h20, 6'h21, 6'h22, 6'h23, 6'h30, 6'h31, 6'h32, 6'h12, 6'h3f, 6'h13};
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", bus_if.in_ready, 1);
        chk("reset.out_valid", bus_if.out_valid, 0);
        chk("reset.res", bus_if.res, 0);
        chk("reset.flags", {bus_if.flag, bus_if.z, bus_if.n, bus_if.err}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_carry", 6'h10, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("sub_borrow", 6'h11, 32'h0000_0001, 32'h0000_0002, 0);
        run_op("le_signed", 6'h22, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("gt_signed", 6'h23, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op("eq", 6'h20, 32'h1234_5678, 32'h1234_5678, 0);
        run_op("neq", 6'h21, 32'h1234_5678, 32'h1234_5678, 0);
        run_op("sra4", 6'h32, 32'h8000_0000, 32'h0000_0004, 0);
        run_op("sll_amt0", 6'h30, 32'h0001_0000, 32'h0000_0020, 0);
        run_op("srl_max", 6'h31, 32'h8000_0001, 32'h0000_001F, 0);
        run_op("sll_max", 6'h30, 32'h0000_0003, 32'hFFFF_FFFF, 0);
        run_op("hold10", 6'h11, 32'h0000_0005, 32'h0000_0009, 10);

        // Abandon a long shift with reset.
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.op_code  = 6'h30;
        bus_if.a        = 32'h0000_0001;
        bus_if.b        = 32'h0000_0014;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.in_ready", bus_if.in_ready, 1);
        chk("rst_mid.out_valid", bus_if.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid.quiet", bus_if.out_valid, 0);
        run_op("add_after_rst", 6'h10, 32'h0000_0002, 32'h0000_0003, 0);
        run_op("illegal_3f", 6'h3f, 32'hDEAD_BEEF, 32'h0000_0007, 0);
        run_op("mul_or_illegal", 6'h12, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("mul_small", 6'h12, 32'h0000_1234, 32'h0000_0101, 0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            run_op("random", op, $urandom, $urandom, (i % 7 == 0) ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
